// File: rtl/dmem_boot_loader_pkg.sv
// Shared definitions for the data-memory boot loader and the blocks it drives
// (data_mem and riscv_cpu use the same StoreSrc encodings).
package dmem_boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } loaderState_e;

  localparam logic [1:0] STORE_BYTE = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_WORD = 2'b10;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_boot_loader_hold_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/dmem_boot_loader.sv
// Boot sequencer: streams host words into data memory while holding the CPU in
// reset, then releases the CPU and hands the data-memory port back to it.
module dmem_boot_loader
  import dmem_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          MAX_WORDS   = 64,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [1:0]  STORE_WORD  = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        ext_valid,
  input  logic [31:0] ext_wdata,
  input  logic        ext_last,
  output logic        ext_ready,
  output logic        cpu_rst,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_store_src,
  output logic [6:0]  word_cnt,
  output logic        load_done
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_WORDS);
  localparam int         HOLD_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  loaderState_e state;
  loaderState_e nextState;
  logic [31:0]  ptr;
  logic         accept;
  logic         finalBeat;
  logic         holdLoad;
  logic         holdDone;

  assign ext_ready = (state == LOAD) && (word_cnt < MAX_CNT) && !abort;
  assign accept    = ext_valid && ext_ready;
  assign finalBeat = ext_last || (word_cnt == (MAX_CNT - 7'd1));

  // The hold count starts on the accept edge of the final beat, so the write
  // cycle itself is followed by exactly HOLD_CYCLES more cycles of cpu_rst.
  hold_timer #(
    .CNT_W (HOLD_W)
  ) u_holdTimer (
    .clk     (clk),
    .reset   (reset),
    .load    (holdLoad),
    .loadVal (HOLD_W'(HOLD_CYCLES)),
    .done    (holdDone)
  );

  always_comb begin
    nextState = state;
    holdLoad  = 1'b0;
    if (abort) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) nextState = LOAD;
        LOAD: begin
          if (accept && finalBeat) begin
            nextState = RELEASE;
            holdLoad  = 1'b1;
          end
        end
        RELEASE: if (holdDone) nextState = RUN;
        RUN:     nextState = RUN;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Write stage: one-cycle registered write following each accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= BASE_ADR;
      word_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_adr   <= ptr;
        mem_wdata <= ext_wdata;
        ptr       <= ptr + 32'(WORD_BYTES);
        word_cnt  <= word_cnt + 7'd1;
      end else if (abort || (state == IDLE)) begin
        ptr      <= BASE_ADR;
        word_cnt <= '0;
      end
    end
  end

  assign cpu_rst       = (state != RUN);
  assign mem_sel       = (state != RUN);
  assign load_done     = (state == RUN);
  assign mem_store_src = STORE_WORD;

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Scoreboard bench for dmem_boot_loader: two instances (base 0x0 and 0x100)
// share one stimulus stream; expected writes are queued per instance.
module tb_dmem_boot_loader;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ext_valid = 1'b0;
  logic [31:0] ext_wdata = '0;
  logic        ext_last = 1'b0;

  logic        readyA, cpuRstA, memSelA, memWeA, loadDoneA;
  logic [31:0] memAdrA, memWdataA;
  logic [1:0]  storeSrcA;
  logic [6:0]  wordCntA;
  logic        readyB, cpuRstB, memSelB, memWeB, loadDoneB;
  logic [31:0] memAdrB, memWdataB;
  logic [1:0]  storeSrcB;
  logic [6:0]  wordCntB;

  wr_t qA[$];
  wr_t qB[$];
  int  nCompared = 0;
  int  nMismatched = 0;

  always #5 clk = ~clk;

  dmem_boot_loader #(.BASE_ADR(BASE_A), .MAX_WORDS(64), .HOLD_CYCLES(4)) u_dutA (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ext_valid(ext_valid), .ext_wdata(ext_wdata), .ext_last(ext_last),
    .ext_ready(readyA), .cpu_rst(cpuRstA), .mem_sel(memSelA), .mem_we(memWeA),
    .mem_adr(memAdrA), .mem_wdata(memWdataA), .mem_store_src(storeSrcA),
    .word_cnt(wordCntA), .load_done(loadDoneA)
  );

  dmem_boot_loader #(.BASE_ADR(BASE_B), .MAX_WORDS(64), .HOLD_CYCLES(4)) u_dutB (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ext_valid(ext_valid), .ext_wdata(ext_wdata), .ext_last(ext_last),
    .ext_ready(readyB), .cpu_rst(cpuRstB), .mem_sel(memSelB), .mem_we(memWeB),
    .mem_adr(memAdrB), .mem_wdata(memWdataB), .mem_store_src(storeSrcB),
    .word_cnt(wordCntB), .load_done(loadDoneB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pushWr(input int idx, input logic [31:0] data);
    qA.push_back('{adr: BASE_A + 32'(4 * idx), data: data});
    qB.push_back('{adr: BASE_B + 32'(4 * idx), data: data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitRun(input string tag);
    int n = 0;
    while (!loadDoneA && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(loadDoneA), 32'd1);
  endtask

  task automatic doAbort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_cpuRst", 32'(cpuRstA), 32'd1);
    chk("abort_memSel", 32'(memSelA), 32'd1);
    chk("abort_loadDone", 32'(loadDoneA), 32'd0);
    step();
  endtask

  task automatic doStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_ready"}, 32'(readyA), 32'd0);
    chk({tag, "_cpuRst"}, 32'(cpuRstA), 32'd1);
    chk({tag, "_memSel"}, 32'(memSelA), 32'd1);
    chk({tag, "_memWe"}, 32'(memWeA), 32'd0);
    chk({tag, "_memAdr"}, memAdrA, 32'd0);
    chk({tag, "_memWdata"}, memWdataA, 32'd0);
    chk({tag, "_storeSrc"}, 32'(storeSrcA), 32'd2);
    chk({tag, "_wordCnt"}, 32'(wordCntA), 32'd0);
    chk({tag, "_loadDone"}, 32'(loadDoneA), 32'd0);
  endtask

  // Write monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (memWeA) begin
      if (qA.size() == 0) begin
        chk("spurious_writeA", memAdrA, 32'hFFFF_FFFF);
      end else begin
        e = qA.pop_front();
        chk("wr_adrA", memAdrA, e.adr);
        chk("wr_dataA", memWdataA, e.data);
      end
    end
    if (memWeB) begin
      if (qB.size() == 0) begin
        chk("spurious_writeB", memAdrB, 32'hFFFF_FFFF);
      end else begin
        e = qB.pop_front();
        chk("wr_adrB", memAdrB, e.adr);
        chk("wr_dataB", memWdataB, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;

    // Reset values
    repeat (3) @(negedge clk);
    checkResetVals("rst");
    step();
    reset = 1'b1;
    step();

    // Three back-to-back beats, last on the third
    doStart();
    ext_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext_wdata = prog[i];
      ext_last  = (i == 2);
      pushWr(i, prog[i]);
      step();
    end
    ext_valid = 1'b0;
    ext_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_holdCpuRst", 32'(cpuRstA), 32'd1);
    end
    @(negedge clk);
    chk("t1_cpuRstFall", 32'(cpuRstA), 32'd0);
    chk("t1_loadDone", 32'(loadDoneA), 32'd1);
    chk("t1_memSel", 32'(memSelA), 32'd0);
    chk("t1_wordCnt", 32'(wordCntA), 32'd3);
    chk("t1_qEmpty", 32'(qA.size()), 32'd0);

    // RUN ignores start and ext_valid
    step();
    start = 1'b1;
    ext_valid = 1'b1;
    ext_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("run_ready", 32'(readyA), 32'd0);
    chk("run_memWe", 32'(memWeA), 32'd0);
    chk("run_memSel", 32'(memSelA), 32'd0);
    chk("run_cpuRst", 32'(cpuRstA), 32'd0);
    step();
    start = 1'b0;
    @(negedge clk);
    chk("run_loadDone", 32'(loadDoneA), 32'd1);
    chk("run_wordCnt", 32'(wordCntA), 32'd3);
    chk("run_memWe2", 32'(memWeA), 32'd0);
    step();
    ext_valid = 1'b0;
    doAbort();
    @(negedge clk);
    chk("idle_wordCnt", 32'(wordCntA), 32'd0);
    step();

    // 70 streamed beats against MAX_WORDS = 64
    doStart();
    ext_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      ext_wdata = 32'h1000_0000 + 32'(i);
      if (i < 64) pushWr(i, ext_wdata);
      if (i == 64) begin
        @(negedge clk);
        chk("max_readyLow", 32'(readyA), 32'd0);
        chk("max_wordCnt", 32'(wordCntA), 32'd64);
        chk("max_release_cpuRst", 32'(cpuRstA), 32'd1);
        chk("max_release_loadDone", 32'(loadDoneA), 32'd0);
      end
      step();
    end
    ext_valid = 1'b0;
    waitRun("max_reachRun");
    chk("max_finalCnt", 32'(wordCntA), 32'd64);
    chk("max_qEmpty", 32'(qA.size()), 32'd0);
    step();
    doAbort();

    // Gapped handshake: valid 1 of every 3 cycles, two beats
    doStart();
    for (int k = 0; k < 6; k++) begin
      ext_valid = (k % 3 == 0);
      ext_wdata = 32'hA000_0000 + 32'(k / 3);
      ext_last  = (k == 3);
      if (k % 3 == 0) pushWr(k / 3, ext_wdata);
      step();
    end
    ext_valid = 1'b0;
    ext_last  = 1'b0;
    waitRun("gap_reachRun");
    chk("gap_wordCnt", 32'(wordCntA), 32'd2);
    chk("gap_qEmptyB", 32'(qB.size()), 32'd0);
    step();
    doAbort();

    // abort together with the second beat
    doStart();
    ext_valid = 1'b1;
    ext_wdata = 32'h1111_1111;
    pushWr(0, ext_wdata);
    step();
    ext_wdata = 32'h2222_2222;
    abort = 1'b1;
    @(negedge clk);
    chk("ab_readyLow", 32'(readyA), 32'd0);
    step();
    abort = 1'b0;
    ext_valid = 1'b0;
    @(negedge clk);
    chk("ab_cpuRst", 32'(cpuRstA), 32'd1);
    chk("ab_memSel", 32'(memSelA), 32'd1);
    chk("ab_idleReady", 32'(readyA), 32'd0);
    chk("ab_qEmpty", 32'(qA.size()), 32'd0);
    step();
    doStart();
    @(negedge clk);
    chk("ab_restartCnt", 32'(wordCntA), 32'd0);
    chk("ab_restartReady", 32'(readyA), 32'd1);
    step();
    ext_valid = 1'b1;
    ext_last  = 1'b1;
    ext_wdata = 32'h3333_3333;
    pushWr(0, ext_wdata);
    step();
    ext_valid = 1'b0;
    ext_last  = 1'b0;
    @(negedge clk);
    chk("ab_restartCnt1", 32'(wordCntA), 32'd1);
    waitRun("ab_reachRun");
    step();
    doAbort();

    // Asynchronous reset in the write cycle discards the write
    doStart();
    ext_valid = 1'b1;
    ext_wdata = 32'hCAFE_F00D;
    step();
    chk("rstmid_preWe", 32'(memWeA), 32'd1);
    reset = 1'b0;
    ext_valid = 1'b0;
    #1;
    chk("rstmid_weDrop", 32'(memWeA), 32'd0);
    @(negedge clk);
    checkResetVals("rstmid");
    step();
    reset = 1'b1;
    repeat (3) step();

    chk("final_qA", 32'(qA.size()), 32'd0);
    chk("final_qB", 32'(qB.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dmem_boot_loader.md
Name: dmem_boot_loader

Overview:
- Boot-time sequencer for the single-cycle RISC-V test top.
- Holds the CPU in reset while a host streams 32-bit words into data memory over a valid/ready handshake.
- Writes words to sequential word addresses, then releases the CPU after a programmable hold-off.
- Owns the data-memory write-port select (loader vs CPU), replacing the ad-hoc reset-qualified muxing of external writes.

Parameters:
- BASE_ADR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 64, maximum words accepted per load; further beats are refused.
- HOLD_CYCLES, 4, cycles the CPU reset stays asserted after the last write.
- STORE_WORD, 2'b10, StoreSrc encoding for a full-word store, driven while the loader owns the port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE.
- abort  input  1  single-cycle pulse; returns to IDLE from any state.
- ext_valid  input  1  host word valid.
- ext_wdata  input  32  host word.
- ext_last  input  1  marks the final word; qualified by ext_valid.
- ext_ready  output  1  loader accepts a beat this cycle.
- cpu_rst  output  1  active-high reset to riscv_cpu.
- mem_sel  output  1  1 = loader drives the data-memory port, 0 = CPU drives it.
- mem_we  output  1  loader write strobe.
- mem_adr  output  32  loader write address, in bytes.
- mem_wdata  output  32  loader write data.
- mem_store_src  output  2  StoreSrc value while mem_sel = 1.
- word_cnt  output  7  words written in the current load.
- load_done  output  1  high in RUN.

Behaviour:
- One clock domain; all state is registered on clk rising edge.
- reset low, asynchronously:
  - state = IDLE, cpu_rst = 1, mem_sel = 1, mem_we = 0.
  - mem_adr = 0, mem_wdata = 0, mem_store_src = STORE_WORD.
  - word_cnt = 0, load_done = 0, ext_ready = 0.
- States: IDLE, LOAD, RELEASE, RUN. cpu_rst = 1 and mem_sel = 1 in IDLE, LOAD and RELEASE; both are 0 in RUN.
- IDLE:
  - start → LOAD next cycle.
  - Internal pointer ptr = BASE_ADR; word_cnt = 0.
- LOAD:
  - ext_ready is combinational: (state == LOAD) && (word_cnt < MAX_WORDS) && !abort.
  - Beat accepted when ext_valid && ext_ready.
  - Write latency is exactly 1 cycle. The cycle after an accept has mem_we = 1 with mem_adr = ptr and mem_wdata = the accepted word. The same edge advances ptr += 4 and word_cnt += 1.
  - mem_we is 0 in every cycle not following an accept. Back-to-back beats give back-to-back writes at consecutive addresses.
  - Accepted beat with ext_last = 1, or the accept that makes word_cnt reach MAX_WORDS → RELEASE. Its write still occurs in the following cycle.
  - Once word_cnt = MAX_WORDS, ext_ready stays 0. A beat with ext_last = 1 that is not accepted has no effect.
  - start while in LOAD is ignored.
- RELEASE:
  - Hold counter loads HOLD_CYCLES on entry.
  - cpu_rst stays 1 for HOLD_CYCLES cycles after the final mem_we cycle.
  - Then → RUN; mem_sel, cpu_rst and load_done change on the same edge.
- RUN:
  - ext_ready = 0; ext_valid and start are ignored.
  - word_cnt holds the final count.
- abort in any state → IDLE next cycle:
  - cpu_rst = 1, load_done = 0, mem_sel = 1.
  - A pending write from a beat accepted in the previous cycle still completes.
  - abort takes priority over a simultaneous ext_valid (the beat is not accepted) and over start.
- ptr arithmetic is 32-bit and wraps modulo 2^32 with no flag. word_cnt never exceeds MAX_WORDS.
- Asynchronous reset mid-LOAD discards any pending write; mem_we drops immediately.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, RELEASE, RUN);
  - the StoreSrc encodings (STORE_BYTE, STORE_HALF, STORE_WORD) also used by data_mem and riscv_cpu;
  - WORD_BYTES = 4.
- One sub-module, hold_timer: a loadable down-counter with a done flag, used in RELEASE.
- The test top's port mux becomes: data-memory inputs = mem_sel ? loader signals : CPU signals.

Test Plan:
- Reset, then start, then 3 back-to-back beats 0x00500093, 0x00100113, 0x002081B3 with ext_last on the third → writes at 0x0, 0x4, 0x8 in three consecutive cycles; word_cnt = 3; cpu_rst falls 4 cycles after the last write; load_done = 1.
- ext_valid held high with 70 beats and MAX_WORDS = 64 → exactly 64 writes, last at 0xFC; ext_ready low afterwards; enters RELEASE.
- Gapped handshake (valid high 1 of every 3 cycles), BASE_ADR = 0x100, 2 beats → writes at 0x100 and 0x104 only; mem_we never high in gap cycles.
- abort asserted in the same cycle as the 2nd beat → beat not accepted; 1 write at BASE_ADR; state IDLE; cpu_rst = 1; a following start restarts at BASE_ADR with word_cnt = 0.
- reset driven low mid-LOAD in the cycle after an accept → mem_we = 0 immediately, all outputs at reset values, no write.
- In RUN, pulse start and drive ext_valid with data 0xDEADBEEF → no state change, mem_we = 0, mem_sel = 0, cpu_rst = 0.
